hazard_control: RTL and testbench

- Produces the stall and flush controls consumed by the fetch/decode, decode/execute and execute/memory pipeline registers.
- Detects load-use hazards, taken-branch redirects, multi-cycle multiply occupancy of execute, and instruction/data cache misses.
- Sits beside the pipeline registers and drives their f_/d_/x_/m_ stall and flush inputs.
- The FSM and counters are registered; the stall and flush outputs are combinational from state plus inputs, so they take effect at the same edge.

---
 rtl/pipeline_pkg.sv | 30 +++
 rtl/hazard_detect.sv | 23 ++
 rtl/hazard_control.sv | 165 ++++++++++++++++
 tb/tb_hazard_control.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcode constants, hazard FSM encoding and
// register-file constants used by the hazard and forwarding logic.
package pipeline_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b000_0011;
    localparam logic [6:0] OP_STORE  = 7'b010_0011;
    localparam logic [6:0] OP_OP     = 7'b011_0011;
    localparam logic [6:0] OP_OP_IMM = 7'b001_0011;
    localparam logic [6:0] OP_BRANCH = 7'b110_0011;
    localparam logic [6:0] OP_JAL    = 7'b110_1111;
    localparam logic [6:0] OP_JALR   = 7'b110_0111;
    // Multi-cycle multiply lives in its own opcode slot so execute can see it
    // without decoding funct fields.
    localparam logic [6:0] OP_MUL    = 7'b000_1011;

    localparam logic [4:0] REG_ZERO  = 5'd0;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        MUL_BUSY    = 2'd1,
        DC_WAIT     = 2'd2,
        DC_WAIT_MUL = 2'd3
    } hc_state_e;

    // True in the states that are waiting for a data-cache line to return.
    function automatic logic in_dc_wait(input hc_state_e st);
        return (st == DC_WAIT) || (st == DC_WAIT_MUL);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in execute and the instruction
// in decode. Purely combinational so the forwarding unit can share it.
module hazard_detect
    import pipeline_pkg::*;
(
    input  logic [4:0] d_src_reg_1,
    input  logic [4:0] d_src_reg_2,
    input  logic       d_uses_src_2,
    input  logic [4:0] x_dst_reg,
    input  logic       x_mem_read,
    output logic       load_use
);

    logic src_1_match_s;
    logic src_2_match_s;

    assign src_1_match_s = (x_dst_reg == d_src_reg_1);
    assign src_2_match_s = d_uses_src_2 & (x_dst_reg == d_src_reg_2);

    // x0 is hardwired, so a load targeting it never creates a dependency.
    assign load_use = x_mem_read & (x_dst_reg != REG_ZERO) & (src_1_match_s | src_2_match_s);

endmodule

// File: rtl/hazard_control.sv
// Pipeline stall/flush controller: combines load-use, multiply occupancy,
// cache misses and taken branches into per-stage stall and flush controls.
module hazard_control
    import pipeline_pkg::*;
#(
    parameter int MUL_LATENCY = 5,
    parameter int CNT_W       = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  d_src_reg_1,
    input  logic [4:0]  d_src_reg_2,
    input  logic        d_uses_src_2,
    input  logic [4:0]  x_dst_reg,
    input  logic        x_mem_read,
    input  logic [6:0]  x_opcode,
    input  logic        x_branch_taken,
    input  logic        ic_miss,
    input  logic        ic_ready,
    input  logic        dc_miss,
    input  logic        dc_ready,
    output logic        f_stall,
    output logic        d_stall,
    output logic        d_flush,
    output logic        f_flush,
    output logic        x_stall,
    output logic        m_stall,
    output logic [31:0] stall_cycles
);

    // A MUL holds execute for MUL_LATENCY-1 cycles: the trigger cycle plus
    // MUL_LOAD+1 counted cycles, releasing when the counter reads zero.
    localparam logic             MUL_STALLS = (MUL_LATENCY > 1) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] MUL_LOAD   = (MUL_LATENCY > 1) ? CNT_W'(MUL_LATENCY - 2)
                                                                : {CNT_W{1'b0}};

    hc_state_e        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      stall_cycles_r;

    logic dc_hold_s;
    logic mul_hold_s;
    logic load_use_s;
    logic x_stall_s;
    logic d_stall_s;
    logic f_stall_s;
    logic flush_s;

    hazard_detect u_hazard_detect (
        .d_src_reg_1  (d_src_reg_1),
        .d_src_reg_2  (d_src_reg_2),
        .d_uses_src_2 (d_uses_src_2),
        .x_dst_reg    (x_dst_reg),
        .x_mem_read   (x_mem_read),
        .load_use     (load_use_s)
    );

    // Memory-stage hold and multiply occupancy hold from FSM state plus inputs.
    always_comb begin
        dc_hold_s  = in_dc_wait(state_r) ? ~dc_ready : dc_miss;
        mul_hold_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!dc_miss && (x_opcode == OP_MUL) && MUL_STALLS) begin
                    mul_hold_s = 1'b1;
                end else begin
                    mul_hold_s = 1'b0;
                end
            end
            MUL_BUSY: begin
                if (!dc_miss) begin
                    mul_hold_s = (cnt_r != {CNT_W{1'b0}});
                end else begin
                    mul_hold_s = 1'b0;
                end
            end
            // The MUL is still parked in execute; the dc_ready cycle must keep
            // it there so it resumes counting from where it was frozen.
            DC_WAIT_MUL: mul_hold_s = 1'b1;
            DC_WAIT:     mul_hold_s = 1'b0;
            default:     mul_hold_s = 1'b0;
        endcase
    end

    // Stage controls; a flush is withheld while execute is held because it
    // would override the hold and destroy the held instruction.
    always_comb begin
        x_stall_s = dc_hold_s | mul_hold_s;
        d_stall_s = x_stall_s | load_use_s;
        f_stall_s = d_stall_s | (ic_miss & ~ic_ready);
        flush_s   = x_branch_taken & ~x_stall_s;
        if (reset) begin
            m_stall = 1'b0;
            x_stall = 1'b0;
            d_stall = 1'b0;
            f_stall = 1'b0;
            d_flush = 1'b0;
            f_flush = 1'b0;
        end else begin
            m_stall = dc_hold_s;
            x_stall = x_stall_s;
            d_stall = d_stall_s;
            f_stall = f_stall_s;
            d_flush = flush_s;
            f_flush = flush_s;
        end
    end

    // FSM, multiply down-counter and saturating fetch-stall counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= IDLE;
            cnt_r          <= {CNT_W{1'b0}};
            stall_cycles_r <= 32'd0;
        end else begin
            if (f_stall_s && (stall_cycles_r != 32'hFFFF_FFFF)) begin
                stall_cycles_r <= stall_cycles_r + 32'd1;
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
            case (state_r)
                IDLE: begin
                    if (dc_miss) begin
                        state_r <= DC_WAIT;
                    end else if (mul_hold_s) begin
                        state_r <= MUL_BUSY;
                        cnt_r   <= MUL_LOAD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                MUL_BUSY: begin
                    if (dc_miss) begin
                        state_r <= DC_WAIT_MUL;
                    end else if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                DC_WAIT: begin
                    if (dc_ready) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= DC_WAIT;
                    end
                end
                DC_WAIT_MUL: begin
                    if (dc_ready) begin
                        state_r <= MUL_BUSY;
                    end else begin
                        state_r <= DC_WAIT_MUL;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_hazard_control.sv
// Directed bench for hazard_control: a cycle-level reference model of the
// stall/flush rules is checked every cycle, plus literal per-scenario totals.
module tb_hazard_control;
    import pipeline_pkg::*;

    localparam int LAT = 5;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  d_src_reg_1, d_src_reg_2, x_dst_reg;
    logic        d_uses_src_2, x_mem_read, x_branch_taken;
    logic [6:0]  x_opcode;
    logic        ic_miss, ic_ready, dc_miss, dc_ready;
    logic        f_stall, d_stall, d_flush, f_flush, x_stall, m_stall;
    logic [31:0] stall_cycles;

    always #5 clock = ~clock;

    hazard_control #(.MUL_LATENCY(LAT), .CNT_W(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .d_src_reg_1    (d_src_reg_1),
        .d_src_reg_2    (d_src_reg_2),
        .d_uses_src_2   (d_uses_src_2),
        .x_dst_reg      (x_dst_reg),
        .x_mem_read     (x_mem_read),
        .x_opcode       (x_opcode),
        .x_branch_taken (x_branch_taken),
        .ic_miss        (ic_miss),
        .ic_ready       (ic_ready),
        .dc_miss        (dc_miss),
        .dc_ready       (dc_ready),
        .f_stall        (f_stall),
        .d_stall        (d_stall),
        .d_flush        (d_flush),
        .f_flush        (f_flush),
        .x_stall        (x_stall),
        .m_stall        (m_stall),
        .stall_cycles   (stall_cycles)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: an outstanding data miss, and how many cycles the MUL
    // in execute still occupies (including its final advancing cycle).
    bit          m_dc_pending = 1'b0;
    int          m_mul_left   = 0;
    logic [31:0] m_stall_cnt  = 32'd0;

    logic s_x, s_d, s_f, s_m, s_dfl, s_ffl;
    logic [31:0] s_sc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Predict this cycle's outputs from the model, compare, then advance the model.
    task automatic model_check();
        bit e_dc, e_mul, e_lu, e_x, e_d, e_f, e_fl;
        if (reset) begin
            {e_x, e_d, e_f, e_fl, e_dc} = 5'b0;
        end else begin
            if (m_dc_pending) begin
                e_dc  = !dc_ready;
                e_mul = (m_mul_left > 0);
                if (dc_ready) m_dc_pending = 1'b0;
            end else if (dc_miss) begin
                e_dc = 1'b1;
                e_mul = 1'b0;
                m_dc_pending = 1'b1;
            end else if (m_mul_left > 0) begin
                e_dc  = 1'b0;
                e_mul = (m_mul_left > 1);
                m_mul_left--;
            end else if (x_opcode == OP_MUL && LAT > 1) begin
                e_dc  = 1'b0;
                e_mul = 1'b1;
                m_mul_left = LAT - 1;
            end else begin
                e_dc  = 1'b0;
                e_mul = 1'b0;
            end
            e_lu = x_mem_read && (x_dst_reg != 5'd0) &&
                   ((x_dst_reg == d_src_reg_1) || (d_uses_src_2 && x_dst_reg == d_src_reg_2));
            e_x  = e_dc || e_mul;
            e_d  = e_x || e_lu;
            e_f  = e_d || (ic_miss && !ic_ready);
            e_fl = x_branch_taken && !e_x;
        end
        check("m_stall", {31'd0, m_stall}, {31'd0, e_dc});
        check("x_stall", {31'd0, x_stall}, {31'd0, e_x});
        check("d_stall", {31'd0, d_stall}, {31'd0, e_d});
        check("f_stall", {31'd0, f_stall}, {31'd0, e_f});
        check("d_flush", {31'd0, d_flush}, {31'd0, e_fl});
        check("f_flush", {31'd0, f_flush}, {31'd0, e_fl});
        check("stall_cycles", stall_cycles, m_stall_cnt);
        if (reset) begin
            m_stall_cnt  = 32'd0;
            m_dc_pending = 1'b0;
            m_mul_left   = 0;
        end else if (e_f && m_stall_cnt != 32'hFFFF_FFFF) begin
            m_stall_cnt = m_stall_cnt + 32'd1;
        end
    endtask

    // One pipeline cycle: inputs already driven; check at negedge, then advance.
    task automatic step();
        @(negedge clock);
        model_check();
        s_x = x_stall; s_d = d_stall; s_f = f_stall; s_m = m_stall;
        s_dfl = d_flush; s_ffl = f_flush; s_sc = stall_cycles;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        d_src_reg_1 = 5'd1; d_src_reg_2 = 5'd2; d_uses_src_2 = 1'b0;
        x_dst_reg = 5'd9; x_mem_read = 1'b0; x_opcode = OP_OP;
        x_branch_taken = 1'b0; ic_miss = 1'b0; ic_ready = 1'b0;
        dc_miss = 1'b0; dc_ready = 1'b0;
    endtask

    initial begin
        int cnt, dcnt;
        logic [31:0] sc0;
        idle();
        reset = 1'b1;
        @(posedge clock);
        #1;
        step();
        check("reset_f_stall", {31'd0, s_f}, 32'd0);
        check("reset_stall_cycles", s_sc, 32'd0);
        reset = 1'b0;
        step();
        step();

        // Load-use on src 1, then src 2, then x0 destination
        x_mem_read = 1'b1; x_dst_reg = 5'd3; d_src_reg_1 = 5'd3; d_src_reg_2 = 5'd7;
        step();
        check("lu_d_stall", {31'd0, s_d}, 32'd1);
        check("lu_f_stall", {31'd0, s_f}, 32'd1);
        check("lu_x_stall", {31'd0, s_x}, 32'd0);
        x_mem_read = 1'b0;
        step();
        check("lu_one_cycle", {31'd0, s_d}, 32'd0);
        x_mem_read = 1'b1; d_src_reg_1 = 5'd4; d_src_reg_2 = 5'd3; d_uses_src_2 = 1'b1;
        step();
        check("lu_src2", {31'd0, s_d}, 32'd1);
        d_uses_src_2 = 1'b0;
        step();
        check("lu_src2_unused", {31'd0, s_d}, 32'd0);
        x_dst_reg = 5'd0; d_src_reg_1 = 5'd0;
        step();
        check("lu_reg_zero", {31'd0, s_d}, 32'd0);
        idle();
        step();

        // Two back-to-back MULs, each LAT cycles in execute
        x_opcode = OP_MUL;
        for (int k = 0; k < 2; k++) begin
            cnt = 0;
            for (int i = 0; i < LAT; i++) begin
                step();
                cnt += int'(s_x);
            end
            check("mul_stall_total", cnt, 32'd4);
            check("mul_release", {31'd0, s_x}, 32'd0);
        end
        x_opcode = OP_OP;
        step();

        // Data miss N..N+5, line returns at N+6
        dc_miss = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            cnt += int'(s_m & s_x & s_d & s_f);
        end
        check("dc_stall_total", cnt, 32'd6);
        dc_ready = 1'b1;
        step();
        check("dc_ready_m_stall", {31'd0, s_m}, 32'd0);
        check("dc_ready_f_stall", {31'd0, s_f}, 32'd0);
        idle();
        step();

        // Data miss arriving mid-MUL freezes the multiply count
        x_opcode = OP_MUL;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            dc_miss  = (i >= 2 && i <= 4);
            dc_ready = (i == 4);
            step();
            cnt += int'(s_x);
        end
        check("mul_dc_stall_total", cnt, 32'd7);
        check("mul_dc_release", {31'd0, s_x}, 32'd0);
        idle();
        step();

        // Taken branch while memory is held: flush only in the dc_ready cycle
        x_branch_taken = 1'b1; dc_miss = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("flush_suppressed", {31'd0, s_dfl}, 32'd0);
        end
        dc_ready = 1'b1;
        step();
        check("flush_d_on_ready", {31'd0, s_dfl}, 32'd1);
        check("flush_f_on_ready", {31'd0, s_ffl}, 32'd1);
        idle();
        step();
        check("flush_off", {31'd0, s_dfl}, 32'd0);

        // Flush together with load-use
        x_branch_taken = 1'b1; x_mem_read = 1'b1; x_dst_reg = 5'd5; d_src_reg_1 = 5'd5;
        step();
        check("flush_with_lu", {31'd0, s_dfl}, 32'd1);
        check("lu_with_flush", {31'd0, s_d}, 32'd1);
        idle();
        step();

        // Instruction miss only stalls fetch
        step();
        sc0 = s_sc;
        ic_miss = 1'b1;
        cnt = 0; dcnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            cnt  += int'(s_f);
            dcnt += int'(s_d);
        end
        check("ic_f_stall_total", cnt, 32'd4);
        check("ic_d_stall_total", dcnt, 32'd0);
        ic_ready = 1'b1;
        step();
        check("ic_ready_f_stall", {31'd0, s_f}, 32'd0);
        idle();
        step();
        check("ic_stall_cycles_delta", s_sc - sc0, 32'd4);

        // Reset in the middle of a MUL with a data miss arriving
        x_opcode = OP_MUL;
        step();
        step();
        reset = 1'b1; dc_miss = 1'b1;
        step();
        check("rst_x_stall", {31'd0, s_x}, 32'd0);
        check("rst_m_stall", {31'd0, s_m}, 32'd0);
        check("rst_f_stall", {31'd0, s_f}, 32'd0);
        reset = 1'b0;
        idle();
        step();
        check("rst_stall_cycles", s_sc, 32'd0);
        check("rst_no_residual", {31'd0, s_x}, 32'd0);

        // Reset in the middle of a data miss
        dc_miss = 1'b1;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        dc_miss = 1'b0;
        step();
        check("rst_dc_no_residual", {31'd0, s_m}, 32'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
